// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect and decode handshake.
// master = fetch unit side, slave = memory/decode/branch side.
interface instr_fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_misalign;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_misalign,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_misalign,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, instr/PC FIFO to decode, redirect flush/drain.
// Optional misaligned-redirect fault with HALT state when IFU_MISALIGN_CHK_EN is defined.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);

`ifdef IFU_MISALIGN_CHK_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_HALT = 2'd3} state_e;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_e;
`endif

   state_e           state_q, state_d, drain_tgt_s, redir_tgt_s;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] outst_q, outst_d, drop_q, drop_d, fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, inf_wr_q, inf_rd_q;
   logic [31:0]      fifo_instr_q [FIFO_DEPTH];
   logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]      inf_pc_q     [FIFO_DEPTH];
   logic             misalign_q, misalign_d;

   logic             redir_s, redir_bad_s, req_valid_s, req_fire_s;
   logic             rsp_pop_s, rsp_drop_s, rsp_keep_s, pop_s;
   logic [31:0]      redir_pc_s;
   logic [CNT_W:0]   credit_s;

   assign redir_s    = bus.redirect_valid && (state_q != ST_IDLE);
   assign redir_pc_s = {bus.redirect_pc[31:2], 2'b00};
`ifdef IFU_MISALIGN_CHK_EN
   assign redir_bad_s = (bus.redirect_pc[1:0] != 2'b00);
`else
   logic unused_s;
   assign unused_s    = ^bus.redirect_pc[1:0];
   assign redir_bad_s = 1'b0;
`endif

   // Outstanding requests plus buffered words bound issue, so the FIFO can never overflow.
   assign credit_s   = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
   assign req_fire_s = req_valid_s && bus.imem_req_ready;
   assign rsp_pop_s  = bus.imem_rsp_valid && (outst_q != CNT_ZERO);
   assign rsp_drop_s = rsp_pop_s && (drop_q != CNT_ZERO);
   assign rsp_keep_s = rsp_pop_s && !rsp_drop_s && !redir_s && (state_q == ST_RUN);
   assign pop_s      = (fifo_cnt_q != CNT_ZERO) && bus.if_ready && !redir_s;

   assign bus.imem_req_valid = req_valid_s;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.if_valid       = (fifo_cnt_q != CNT_ZERO);
   assign bus.if_instr       = fifo_instr_q[rd_ptr_q];
   assign bus.if_pc          = fifo_pc_q[rd_ptr_q];
   assign bus.if_misalign    = misalign_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a redirect re-targets from any non-IDLE state
   always_comb begin
      drain_tgt_s = (drop_d != CNT_ZERO) ? ST_DRAIN : ST_RUN;
`ifdef IFU_MISALIGN_CHK_EN
      redir_tgt_s = redir_bad_s ? ST_HALT : drain_tgt_s;
`else
      redir_tgt_s = drain_tgt_s;
`endif
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_RUN;
         ST_RUN:   state_d = redir_s ? redir_tgt_s : ST_RUN;
         ST_DRAIN: state_d = redir_s ? redir_tgt_s : drain_tgt_s;
`ifdef IFU_MISALIGN_CHK_EN
         ST_HALT:  state_d = redir_s ? redir_tgt_s : ST_HALT;
`endif
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM output: request only in RUN, with credit, and never in a redirect cycle
   always_comb begin
      if ((state_q == ST_RUN) && !bus.redirect_valid && (credit_s < DEPTH_C)) begin
         req_valid_s = 1'b1;
      end else begin
         req_valid_s = 1'b0;
      end
   end

   // Counter, PC and fault next-state; after a redirect every still-pending response is dropped
   always_comb begin
      if (req_fire_s && !rsp_pop_s) begin
         outst_d = outst_q + CNT_ONE;
      end else if (!req_fire_s && rsp_pop_s) begin
         outst_d = outst_q - CNT_ONE;
      end else begin
         outst_d = outst_q;
      end

      if (redir_s) begin
         drop_d = rsp_pop_s ? (outst_q - CNT_ONE) : outst_q;
      end else if (rsp_drop_s) begin
         drop_d = drop_q - CNT_ONE;
      end else begin
         drop_d = drop_q;
      end

      if (redir_s) begin
         fifo_cnt_d = CNT_ZERO;
      end else if (rsp_keep_s && !pop_s) begin
         fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      end else if (!rsp_keep_s && pop_s) begin
         fifo_cnt_d = fifo_cnt_q - CNT_ONE;
      end else begin
         fifo_cnt_d = fifo_cnt_q;
      end

      if (redir_s) begin
         fetch_pc_d = redir_pc_s;
      end else if (req_fire_s) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end

      misalign_d = redir_s ? redir_bad_s : misalign_q;
   end

   // Counter, PC and fault registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         outst_q    <= CNT_ZERO;
         drop_q     <= CNT_ZERO;
         fifo_cnt_q <= CNT_ZERO;
         misalign_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         fifo_cnt_q <= fifo_cnt_d;
         misalign_q <= misalign_d;
      end
   end

   // In-flight PC queue and instr/PC FIFO storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr_q[i] <= 32'h0000_0000;
            fifo_pc_q[i]    <= 32'h0000_0000;
            inf_pc_q[i]     <= 32'h0000_0000;
         end
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         inf_wr_q <= PTR_ZERO;
         inf_rd_q <= PTR_ZERO;
      end else begin
         if (req_fire_s) begin
            inf_pc_q[inf_wr_q] <= fetch_pc_q;
            inf_wr_q           <= inf_wr_q + PTR_ONE;
         end
         if (rsp_pop_s) begin
            inf_rd_q <= inf_rd_q + PTR_ONE;
         end
         if (redir_s) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
         end else begin
            if (rsp_keep_s) begin
               fifo_instr_q[wr_ptr_q] <= bus.imem_rsp_data;
               fifo_pc_q[wr_ptr_q]    <= inf_pc_q[inf_rd_q];
               wr_ptr_q               <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model with programmable latency,
// scoreboard of expected {instr, pc} per accepted request, redirect vector table and corner sequences.
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus ();
   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] rpc; logic [31:0] pc0; logic [31:0] pc1; logic mis; } vec_t;

   exp_t        exp_q[$];
   mreq_t       mem_q[$];
   logic [31:0] pop_log[$];
   logic [31:0] fire_log[$];
   vec_t        vec[4];
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_fires = 0;
   int          cyc = 0;
   int          lat = 1;
   logic [31:0] model_pc;
   logic        obs_req_valid, obs_if_valid, obs_misalign;
   logic [31:0] obs_if_pc, obs_if_instr;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h5EED_C0DE;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: entered just after a negedge with inputs set; returns at the next negedge.
   task automatic step();
      logic  fire, pop;
      exp_t  e;
      mreq_t m;
      #1;
      obs_req_valid = bus.imem_req_valid;
      obs_if_valid  = bus.if_valid;
      obs_if_pc     = bus.if_pc;
      obs_if_instr  = bus.if_instr;
      obs_misalign  = bus.if_misalign;
      fire = bus.imem_req_valid && bus.imem_req_ready;
      pop  = bus.if_valid && bus.if_ready;
      if (bus.redirect_valid) check("no_req_on_redirect", {31'd0, bus.imem_req_valid}, 32'd0);
      if (fire) begin
         check("req_addr", bus.imem_req_addr, model_pc);
         mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
         fire_log.push_back(bus.imem_req_addr);
         n_fires++;
      end
      if (pop && !bus.redirect_valid) begin
         pop_log.push_back(bus.if_pc);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc %h, expected no entry", bus.if_pc);
         end else begin
            e = exp_q.pop_front();
            check("if_pc", bus.if_pc, e.pc);
            check("if_instr", bus.if_instr, e.instr);
         end
      end
      if (bus.redirect_valid) begin
         exp_q.delete();
         model_pc = {bus.redirect_pc[31:2], 2'b00};
      end else if (fire) begin
         exp_q.push_back('{instr: word(model_pc), pc: model_pc});
         model_pc = model_pc + 32'd4;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if ((mem_q.size() != 0) && (mem_q[0].due <= cyc)) begin
         m = mem_q.pop_front();
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = word(m.addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'h0000_0000;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Stop issuing and let every expected entry reach decode.
   task automatic drain(input int budget);
      int k;
      k = 0;
      bus.imem_req_ready = 1'b0;
      bus.if_ready       = 1'b1;
      while ((exp_q.size() != 0) && (k < budget)) begin
         step();
         k++;
      end
      check("drain_left", exp_q.size(), 32'd0);
      bus.imem_req_ready = 1'b1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      step();
      bus.redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0000_0000;
      bus.redirect_valid = 1'b0;
      mem_q.delete();
      exp_q.delete();
      model_pc = 32'h0000_0000;
      #1;
      check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      check("rst_req_addr", bus.imem_req_addr, 32'h0000_0000);
      check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
      check("rst_if_pc", bus.if_pc, 32'h0000_0000);
      check("rst_if_instr", bus.if_instr, 32'h0000_0000);
      check("rst_misalign", {31'd0, bus.if_misalign}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
      $fatal(1);
   end

   initial begin
      int k, f0;
      vec[0] = '{rpc: 32'h0000_0100, pc0: 32'h0000_0100, pc1: 32'h0000_0104, mis: 1'b0};
      vec[1] = '{rpc: 32'hFFFF_FFFC, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000, mis: 1'b0};
      vec[2] = '{rpc: 32'h0000_1000, pc0: 32'h0000_1000, pc1: 32'h0000_1004, mis: 1'b0};
`ifdef IFU_MISALIGN_CHK_EN
      vec[3] = '{rpc: 32'h0000_0208, pc0: 32'h0000_0208, pc1: 32'h0000_020C, mis: 1'b0};
`else
      vec[3] = '{rpc: 32'h0000_0102, pc0: 32'h0000_0100, pc1: 32'h0000_0104, mis: 1'b0};
`endif
      rst_n              = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0000_0000;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0000_0000;
      bus.if_ready       = 1'b0;
      model_pc           = 32'h0000_0000;
      @(negedge clk);
      do_reset();

      // Sequential fetch from reset, one-cycle memory
      bus.imem_req_ready = 1'b1;
      bus.if_ready       = 1'b1;
      step();
      check("idle_no_req", {31'd0, obs_req_valid}, 32'd0);
      step();
      check("run_first_req", {31'd0, obs_req_valid}, 32'd1);
      pop_log.delete();
      run(12);
      check("seq_pops", {31'd0, pop_log.size() >= 3}, 32'd1);
      if (pop_log.size() >= 3) begin
         check("seq_pc0", pop_log[0], 32'h0000_0000);
         check("seq_pc1", pop_log[1], 32'h0000_0004);
         check("seq_pc2", pop_log[2], 32'h0000_0008);
      end

      // Decode stall: only FIFO_DEPTH requests, head held
      bus.if_ready = 1'b0;
      redirect(32'h0000_0040);
      f0 = n_fires;
      for (int i = 0; i < 10; i++) begin
         step();
         if (i == 5 || i == 9) begin
            check("stall_if_valid", {31'd0, obs_if_valid}, 32'd1);
            check("stall_if_pc", obs_if_pc, 32'h0000_0040);
            check("stall_if_instr", obs_if_instr, word(32'h0000_0040));
         end
      end
      check("stall_req_count", n_fires - f0, 32'd2);
      check("stall_no_req", {31'd0, obs_req_valid}, 32'd0);
      bus.if_ready = 1'b1;
      run(8);
      drain(40);

      // Redirect with two requests in flight, three-cycle memory
      lat = 3;
      redirect(32'h0000_0080);
      f0 = n_fires;
      run(2);
      check("two_outstanding", n_fires - f0, 32'd2);
      redirect(32'h0000_0100);
      pop_log.delete();
      step();
      check("drain_no_req_a", {31'd0, obs_req_valid}, 32'd0);
      step();
      check("drain_no_req_b", {31'd0, obs_req_valid}, 32'd0);
      run(10);
      drain(40);
      check("drain_pops", {31'd0, pop_log.size() != 0}, 32'd1);
      if (pop_log.size() != 0) check("drain_first_pc", pop_log[0], 32'h0000_0100);

      // Redirect coinciding with a response
      lat = 1;
      run(4);
      k = 0;
      while (!bus.imem_rsp_valid && (k < 10)) begin
         step();
         k++;
      end
      check("rsp_in_redirect_cycle", {31'd0, bus.imem_rsp_valid}, 32'd1);
      redirect(32'h0000_0300);
      fire_log.delete();
      k = 0;
      while ((fire_log.size() == 0) && (k < 10)) begin
         step();
         k++;
      end
      check("post_redirect_fire", {31'd0, fire_log.size() != 0}, 32'd1);
      if (fire_log.size() != 0) check("post_redirect_addr", fire_log[0], 32'h0000_0300);
      run(6);
      drain(40);

      // Redirect target table
      for (int v = 0; v < 4; v++) begin
         bus.imem_req_ready = 1'b1;
         bus.if_ready       = 1'b1;
         redirect(vec[v].rpc);
         pop_log.delete();
         k = 0;
         while ((pop_log.size() < 2) && (k < 40)) begin
            step();
            k++;
         end
         check("vec_pops", {31'd0, pop_log.size() >= 2}, 32'd1);
         if (pop_log.size() >= 2) begin
            check("vec_pc0", pop_log[0], vec[v].pc0);
            check("vec_pc1", pop_log[1], vec[v].pc1);
         end
         check("vec_misalign", {31'd0, obs_misalign}, {31'd0, vec[v].mis});
      end
      drain(40);

`ifdef IFU_MISALIGN_CHK_EN
      // Misaligned redirect halts until an aligned one
      bus.imem_req_ready = 1'b1;
      run(3);
      redirect(32'h0000_0102);
      for (int i = 0; i < 5; i++) begin
         step();
         check("halt_no_req", {31'd0, obs_req_valid}, 32'd0);
         check("halt_if_valid", {31'd0, obs_if_valid}, 32'd0);
         check("halt_misalign", {31'd0, obs_misalign}, 32'd1);
      end
      redirect(32'h0000_0200);
      pop_log.delete();
      step();
      check("unhalt_misalign", {31'd0, obs_misalign}, 32'd0);
      run(6);
      drain(40);
      check("unhalt_pops", {31'd0, pop_log.size() != 0}, 32'd1);
      if (pop_log.size() != 0) check("unhalt_first_pc", pop_log[0], 32'h0000_0200);
`endif

      // Reset mid-operation restarts from RESET_PC
      bus.imem_req_ready = 1'b1;
      run(5);
      do_reset();
      pop_log.delete();
      step();
      check("rerst_idle_no_req", {31'd0, obs_req_valid}, 32'd0);
      run(8);
      drain(40);
      check("rerst_pops", {31'd0, pop_log.size() != 0}, 32'd1);
      if (pop_log.size() != 0) check("rerst_first_pc", pop_log[0], 32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
